dm_be_responder: RTL and testbench

//  Data-memory responder at the far end of the store byte-enable interface.
//  - Consumes word address, 4-bit byte enables and store data; commits only the enabled byte lanes.
//  - For loads, extracts the addressed byte or halfword and sign- or zero-extends it.
//  - Sits in the MEM stage behind a valid/ready request channel; returns a one-cycle response

---
 rtl/dm_be_responder_pkg.sv | 57 +++++
 rtl/dm_be_responder_if.sv | 28 ++
 rtl/dm_be_responder_load_ext.sv | 51 +++++
 rtl/dm_be_responder.sv | 129 ++++++++++++
 tb/tb_dm_be_responder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/dm_be_responder_pkg.sv
// Shared definitions for the data-memory byte-enable responder.
// Holds load/store codes, FSM state encodings, the legal byte-enable mask list and small helpers.
// No ports; imported by the interface, the load extractor and the top.
package dm_be_responder_pkg;

   // Load type codes carried on L_Instr.
   typedef enum logic [2:0] {
      LD_LW  = 3'b000,
      LD_LH  = 3'b001,
      LD_LHU = 3'b010,
      LD_LB  = 3'b011,
      LD_LBU = 3'b100
   } ld_code_e;

   // Store type codes as produced upstream; the responder only sees the resulting BE.
   typedef enum logic [2:0] {
      ST_SW = 3'b000,
      ST_SH = 3'b001,
      ST_SB = 3'b010
   } st_code_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Byte-enable patterns a store may carry: none, any single byte, either halfword, full word.
   localparam int N_LEGAL_BE = 8;
   localparam logic [N_LEGAL_BE-1:0][3:0] LEGAL_BE = {
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111
   };

   // Latched request fields.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [2:0]  l_instr;
   } req_t;

   function automatic logic be_legal(input logic [3:0] be);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < N_LEGAL_BE; i++) begin
         if (be == LEGAL_BE[i]) ok = 1'b1;
      end
      return ok;
   endfunction

   function automatic logic ld_legal(input logic [2:0] code);
      return (code <= LD_LBU);
   endfunction

endpackage

// File: rtl/dm_be_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
// Request: req_valid/req_ready handshake with we, Addr, BE, WD, L_Instr.
// Response: single-cycle rsp_valid with RD and rsp_err.
interface dm_be_responder_if;
   import dm_be_responder_pkg::*;

   logic        req_valid;
   logic        req_ready;
   logic        we;
   logic [31:0] Addr;
   logic [3:0]  BE;
   logic [31:0] WD;
   logic [2:0]  L_Instr;
   logic        rsp_valid;
   logic [31:0] RD;
   logic        rsp_err;

   modport master (
      output req_valid, we, Addr, BE, WD, L_Instr,
      input  req_ready, rsp_valid, RD, rsp_err
   );

   modport slave (
      input  req_valid, we, Addr, BE, WD, L_Instr,
      output req_ready, rsp_valid, RD, rsp_err
   );

endinterface

// File: rtl/dm_be_responder_load_ext.sv
// Load extractor: selects the addressed byte/halfword/word and sign- or zero-extends it.
// Latency: combinational. Backpressure: none.
// Ports: word_i (memory word), off_i (Addr[1:0]), l_instr_i (load code) -> rd_o, misalign_o.
module dm_be_responder_load_ext
   import dm_be_responder_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  l_instr_i,
   output logic [31:0] rd_o,
   output logic        misalign_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = word_i[7:0];
      case (off_i)
         2'd1:    byte_v = word_i[15:8];
         2'd2:    byte_v = word_i[23:16];
         2'd3:    byte_v = word_i[31:24];
         default: byte_v = word_i[7:0];
      endcase
      half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
   end

   // Illegal codes yield zero with no misalign flag; the caller reports them separately.
   always_comb begin
      rd_o       = '0;
      misalign_o = 1'b0;
      case (l_instr_i)
         LD_LW: begin
            rd_o       = word_i;
            misalign_o = (off_i != 2'd0);
         end
         LD_LH: begin
            rd_o       = {{16{half_v[15]}}, half_v};
            misalign_o = off_i[0];
         end
         LD_LHU: begin
            rd_o       = {16'h0000, half_v};
            misalign_o = off_i[0];
         end
         LD_LB:   rd_o = {{24{byte_v[7]}}, byte_v};
         LD_LBU:  rd_o = {24'h000000, byte_v};
         default: rd_o = '0;
      endcase
   end

endmodule

// File: rtl/dm_be_responder.sv
// Data-memory responder: byte-lane stores and extended loads behind a valid/ready request channel.
// Latency: response in the cycle N+1+WAIT_CYCLES for a request accepted at edge N; one-cycle rsp_valid.
// Backpressure: req_ready low only while counting wait states; back-to-back accept in the response cycle.
// Ports: clk_i, reset_i (async, active high), bus (slave side of dm_be_responder_if).
module dm_be_responder
   import dm_be_responder_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 10,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic             clk_i,
   input  logic             reset_i,
   dm_be_responder_if.slave bus
);

   localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_e      state_q;
   logic [3:0]  cnt_q;
   req_t        req_q;
   logic        rsp_valid_q;
   logic [31:0] rd_q;
   logic        err_q;

   logic [31:0] mem [2**ADDR_WIDTH];

   req_t                  in_req;
   req_t                  cmt_req;
   logic                  req_ready;
   logic                  accept;
   logic                  cmt_en;
   logic [31:0]           word_off;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  in_range;
   logic [31:0]           rd_word;
   logic [31:0]           ext_rd;
   logic                  misalign;
   logic                  cmt_err;
   logic                  mem_we;

   assign in_req = '{we: bus.we, addr: bus.Addr, be: bus.BE, wd: bus.WD, l_instr: bus.L_Instr};

   assign req_ready = (state_q != S_WAIT);
   assign accept    = bus.req_valid && req_ready;

   // Commit happens on the edge that enters RESP. Without wait states that is the accept edge
   // itself, so the live bus fields are used; otherwise the latched copy is.
   assign cmt_req = (WAIT_CYCLES == 0) ? in_req : req_q;
   assign cmt_en  = (WAIT_CYCLES == 0) ? accept
                                       : ((state_q == S_WAIT) && (cnt_q == WAIT_LAST));

   // Word offset from the base; anything above the memory index bits is out of range.
   assign word_off = (cmt_req.addr - BASE_ADDR) >> 2;
   assign idx      = word_off[ADDR_WIDTH-1:0];
   assign in_range = (word_off[31:ADDR_WIDTH] == '0);
   assign rd_word  = mem[idx];

   dm_be_responder_load_ext u_load_ext (
      .word_i     (rd_word),
      .off_i      (cmt_req.addr[1:0]),
      .l_instr_i  (cmt_req.l_instr),
      .rd_o       (ext_rd),
      .misalign_o (misalign)
   );

   always_comb begin
      cmt_err = 1'b0;
      if (!in_range) begin
         cmt_err = 1'b1;
      end else if (cmt_req.we) begin
         cmt_err = !be_legal(cmt_req.be);
      end else begin
         cmt_err = !ld_legal(cmt_req.l_instr) || misalign;
      end
   end

   // Reset gates the write so a store racing an asserted reset never lands.
   assign mem_we = cmt_en && cmt_req.we && !cmt_err && !reset_i;

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (cmt_req.be[i]) mem[idx][8*i +: 8] <= cmt_req.wd[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         req_q       <= '0;
         rsp_valid_q <= 1'b0;
         rd_q        <= '0;
         err_q       <= 1'b0;
      end else begin
         rsp_valid_q <= cmt_en;
         if (cmt_en) begin
            rd_q  <= (cmt_err || cmt_req.we) ? 32'h0 : ext_rd;
            err_q <= cmt_err;
         end
         case (state_q)
            S_WAIT: begin
               if (cnt_q == WAIT_LAST) begin
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: begin
               if (accept) begin
                  req_q   <= in_req;
                  cnt_q   <= '0;
                  state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
               end else begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.RD        = rd_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dm_be_responder.sv
// Directed bench for dm_be_responder with three wait states.
// Drives requests on the negative edge and samples one time unit after the rising edge.
// Ports: none (top-level bench).
module tb_dm_be_responder;

   localparam int WAITS = 3;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   dm_be_responder_if bus_if ();

   dm_be_responder #(
      .ADDR_WIDTH  (10),
      .WAIT_CYCLES (WAITS),
      .BASE_ADDR   (32'h0000_0000)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [2:0] li);
      bus_if.we        = w;
      bus_if.Addr      = a;
      bus_if.BE        = be;
      bus_if.WD        = wd;
      bus_if.L_Instr   = li;
      bus_if.req_valid = 1'b1;
   endtask

   // One request from IDLE: checks wait-state backpressure, latency, result and pulse width.
   task automatic req(input string tag, input logic w, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [2:0] li,
                      input logic [31:0] exp_rd, input logic exp_err);
      int edges;
      @(negedge clk);
      drive(w, a, be, wd, li);
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
      bus_if.WD        = 32'h5A5A_5A5A;
      chk({tag, " ready_in_wait"}, {31'd0, bus_if.req_ready}, 32'd0);
      edges = 0;
      while (!bus_if.rsp_valid && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk({tag, " latency"}, 32'(edges), 32'(WAITS));
      chk({tag, " rd"}, bus_if.RD, exp_rd);
      chk({tag, " err"}, {31'd0, bus_if.rsp_err}, {31'd0, exp_err});
      @(posedge clk);
      #1;
      chk({tag, " pulse"}, {31'd0, bus_if.rsp_valid}, 32'd0);
   endtask

   initial begin
      int seen;
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      bus_if.req_valid = 1'b0;
      bus_if.we        = 1'b0;
      bus_if.Addr      = '0;
      bus_if.BE        = '0;
      bus_if.WD        = '0;
      bus_if.L_Instr   = '0;

      // Reset state
      #12;
      chk("rst req_ready", {31'd0, bus_if.req_ready}, 32'd1);
      chk("rst rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
      chk("rst rd", bus_if.RD, 32'd0);
      chk("rst err", {31'd0, bus_if.rsp_err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Reset mid-store: baseline value, then a store aborted during WAIT
      req("sw base", 1'b1, 32'h20, 4'b1111, 32'h1122_3344, 3'b000, 32'h0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h20, 4'b1111, 32'hDEAD_BEEF, 3'b000);
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("midrst rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
      chk("midrst req_ready", {31'd0, bus_if.req_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus_if.rsp_valid) seen++;
      end
      chk("midrst no_rsp", 32'(seen), 32'd0);
      req("midrst lw", 1'b0, 32'h20, 4'b0000, 32'h0, 3'b000, 32'h1122_3344, 1'b0);

      // SW then LW
      req("sw 10", 1'b1, 32'h10, 4'b1111, 32'h8899_AABB, 3'b000, 32'h0, 1'b0);
      req("lw 10", 1'b0, 32'h10, 4'b0000, 32'h0, 3'b000, 32'h8899_AABB, 1'b0);

      // Byte store and byte loads
      req("sb 13", 1'b1, 32'h13, 4'b1000, 32'hF000_0000, 3'b000, 32'h0, 1'b0);
      req("lw 10b", 1'b0, 32'h10, 4'b0000, 32'h0, 3'b000, 32'hF099_AABB, 1'b0);
      req("lb 13", 1'b0, 32'h13, 4'b0000, 32'h0, 3'b011, 32'hFFFF_FFF0, 1'b0);
      req("lbu 13", 1'b0, 32'h13, 4'b0000, 32'h0, 3'b100, 32'h0000_00F0, 1'b0);

      // Halfword loads
      req("lh 12", 1'b0, 32'h12, 4'b0000, 32'h0, 3'b001, 32'hFFFF_F099, 1'b0);
      req("lhu 10", 1'b0, 32'h10, 4'b0000, 32'h0, 3'b010, 32'h0000_AABB, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rd hold", bus_if.RD, 32'h0000_AABB);
      req("lh 11", 1'b0, 32'h11, 4'b0000, 32'h0, 3'b001, 32'h0, 1'b1);

      // Back-to-back with req_valid held high across two requests
      @(negedge clk);
      drive(1'b0, 32'h10, 4'b0000, 32'h0, 3'b000);
      @(posedge clk);
      #1;
      drive(1'b0, 32'h12, 4'b0000, 32'h0, 3'b100);
      chk("b2b ready_w1", {31'd0, bus_if.req_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("b2b ready_w2", {31'd0, bus_if.req_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("b2b ready_w3", {31'd0, bus_if.req_ready}, 32'd0);
      chk("b2b early", {31'd0, bus_if.rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("b2b rsp1 valid", {31'd0, bus_if.rsp_valid}, 32'd1);
      chk("b2b rsp1 rd", bus_if.RD, 32'hF099_AABB);
      chk("b2b rsp1 ready", {31'd0, bus_if.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
      chk("b2b accepted", {31'd0, bus_if.req_ready}, 32'd0);
      chk("b2b rsp1 pulse", {31'd0, bus_if.rsp_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("b2b rsp2 early", {31'd0, bus_if.rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("b2b rsp2 valid", {31'd0, bus_if.rsp_valid}, 32'd1);
      chk("b2b rsp2 rd", bus_if.RD, 32'h0000_0099);
      @(posedge clk);
      #1;
      chk("b2b rsp2 pulse", {31'd0, bus_if.rsp_valid}, 32'd0);

      // Illegal stores and loads
      req("sw be0110", 1'b1, 32'h10, 4'b0110, 32'hFFFF_FFFF, 3'b000, 32'h0, 1'b1);
      req("lw after bad", 1'b0, 32'h10, 4'b0000, 32'h0, 3'b000, 32'hF099_AABB, 1'b0);
      req("sw oor", 1'b1, 32'h1000, 4'b1111, 32'h1234_5678, 3'b000, 32'h0, 1'b1);
      req("lw oor", 1'b0, 32'h1000, 4'b0000, 32'h0, 3'b000, 32'h0, 1'b1);
      req("sw be0000", 1'b1, 32'h10, 4'b0000, 32'h1234_5678, 3'b000, 32'h0, 1'b0);
      req("lw after be0", 1'b0, 32'h10, 4'b0000, 32'h0, 3'b000, 32'hF099_AABB, 1'b0);
      req("lw misalign", 1'b0, 32'h12, 4'b0000, 32'h0, 3'b000, 32'h0, 1'b1);
      req("ld illegal", 1'b0, 32'h10, 4'b0000, 32'h0, 3'b101, 32'h0, 1'b1);
      req("sh hi", 1'b1, 32'h12, 4'b1100, 32'h5566_0000, 3'b000, 32'h0, 1'b0);
      req("lw after sh", 1'b0, 32'h10, 4'b0000, 32'h0, 3'b000, 32'h5566_AABB, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
